// File: rtl/sc_csr_pkg.sv
// Shared constants for the machine-mode CSR / interrupt block: CSR addresses,
// mstatus field positions, the MEIP bit and the external-interrupt cause code.
package sc_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MEIP_BIT       = 11;

  localparam logic [31:0] INTR_CAUSE = 32'h8000_000B;

  // Trap vectors and return addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sc_intr_sync.sv
// Two-flop synchronizer for the raw external interrupt line, plus a third
// flop holding the previous synchronized value for rising-edge detection.
module sc_intr_sync (
  input  logic clk,
  input  logic reset,
  input  logic intr,
  output logic intr_synced,
  output logic intr_rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= intr;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign intr_synced = sync_q;
  assign intr_rise   = sync_q & ~prev_q;

endmodule

// File: rtl/sc_csr_intr.sv
// Machine-mode trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause) with an
// edge-triggered external interrupt pending bit fed from a synchronizer.
module sc_csr_intr
  import sc_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        intr,
  output logic        intr_synced,
  input  logic        intr_ack,
  input  logic        exc,
  input  logic        mret,
  input  logic        wsta,
  input  logic        wcau,
  input  logic        wepc,
  input  logic        csr_rw,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] cause_in,
  input  logic [31:0] pc,
  output logic [31:0] mstatus,
  output logic [31:0] mie,
  output logic [31:0] mip,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] exc_base,
  output logic [31:0] csr_rdata
);

  logic        intr_rise;
  logic        st_mie_q;
  logic        st_mpie_q;
  logic [1:0]  st_mpp_q;
  logic        mie_meie_q;
  logic        meip_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic        csr_wr_ok;

  sc_intr_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .intr        (intr),
    .intr_synced (intr_synced),
    .intr_rise   (intr_rise)
  );

  // Traps and mret take priority over a plain CSR write in the same cycle.
  assign csr_wr_ok = csr_rw & ~exc & ~mret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      st_mpp_q  <= 2'b00;
    end else if (wsta) begin
      st_mpp_q <= 2'b11;
      if (exc) begin
        st_mpie_q <= st_mie_q;
        st_mie_q  <= 1'b0;
      end else if (mret) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end else begin
        st_mie_q  <= csr_wdata[MSTATUS_MIE];
        st_mpie_q <= csr_wdata[MSTATUS_MPIE];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_meie_q <= 1'b0;
    end else if (csr_wr_ok && csr_addr == CSR_MIE) begin
      mie_meie_q <= csr_wdata[MEIP_BIT];
    end
  end

  // A fresh edge beats a simultaneous acknowledge so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meip_q <= 1'b0;
    end else if (intr_rise) begin
      meip_q <= 1'b1;
    end else if (intr_ack) begin
      meip_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtvec_q <= MTVEC_RESET;
    end else if (csr_wr_ok && csr_addr == CSR_MTVEC) begin
      mtvec_q <= word_align(csr_wdata);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepc_q <= 32'h0;
    end else if (wepc) begin
      mepc_q <= exc ? word_align(pc) : word_align(csr_wdata);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcause_q <= 32'h0;
    end else if (wcau) begin
      if (exc) begin
        mcause_q <= intr_ack ? INTR_CAUSE : cause_in;
      end else begin
        mcause_q <= csr_wdata;
      end
    end
  end

  assign mstatus  = {19'b0, st_mpp_q, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
  assign mie      = {20'b0, mie_meie_q, 11'b0};
  assign mip      = {20'b0, meip_q, 11'b0};
  assign mepc     = mepc_q;
  assign mcause   = mcause_q;
  assign exc_base = word_align(mtvec_q);

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus;
      CSR_MIE:     csr_rdata = mie;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MIP:     csr_rdata = mip;
      default:     csr_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_sc_csr_intr.sv
// Directed testbench for sc_csr_intr: reset values, interrupt synchronizer
// timing, trap entry/return, CSR writes and reset interaction with intr.
module tb_sc_csr_intr;

  logic        clk;
  logic        reset;
  logic        intr;
  logic        intr_synced;
  logic        intr_ack;
  logic        exc;
  logic        mret;
  logic        wsta;
  logic        wcau;
  logic        wepc;
  logic        csr_rw;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] cause_in;
  logic [31:0] pc;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mip;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] exc_base;
  logic [31:0] csr_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sc_csr_intr #(.MTVEC_RESET(32'h0000_0008)) dut (
    .clk         (clk),
    .reset       (reset),
    .intr        (intr),
    .intr_synced (intr_synced),
    .intr_ack    (intr_ack),
    .exc         (exc),
    .mret        (mret),
    .wsta        (wsta),
    .wcau        (wcau),
    .wepc        (wepc),
    .csr_rw      (csr_rw),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .cause_in    (cause_in),
    .pc          (pc),
    .mstatus     (mstatus),
    .mie         (mie),
    .mip         (mip),
    .mepc        (mepc),
    .mcause      (mcause),
    .exc_base    (exc_base),
    .csr_rdata   (csr_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    intr_ack  = 1'b0;
    exc       = 1'b0;
    mret      = 1'b0;
    wsta      = 1'b0;
    wcau      = 1'b0;
    wepc      = 1'b0;
    csr_rw    = 1'b0;
    csr_wdata = 32'h0;
    cause_in  = 32'h0;
    pc        = 32'h0;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [6];
    logic [31:0] exps  [6];
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    exps  = '{32'h0, 32'h0, 32'h0000_0008, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    intr  = 1'b0;
    csr_addr = 12'h0;
    clear_strobes();
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (intr_synced !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_intr_synced: got %b expected 0", intr_synced);
    end
    n_checks++;
    if (exc_base !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL reset_exc_base: got %h expected 00000008", exc_base);
    end
    for (int i = 0; i < 6; i++) begin
      csr_addr = addrs[i];
      #1;
      n_checks++;
      if (csr_rdata !== exps[i]) begin
        n_fail++;
        $display("FAIL reset_read_%h: got %h expected %h", addrs[i], csr_rdata, exps[i]);
      end
      $display("read addr=%h data=%h", addrs[i], csr_rdata);
    end
  endtask

  task automatic test_intr_sync();
    intr = 1'b1;
    tick();
    n_checks++;
    if (intr_synced !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_cycle1: got %b expected 0", intr_synced);
    end
    tick();
    n_checks++;
    if (intr_synced !== 1'b1 || mip !== 32'h0) begin
      n_fail++;
      $display("FAIL sync_cycle2: got synced=%b mip=%h expected synced=1 mip=00000000", intr_synced, mip);
    end
    tick();
    n_checks++;
    if (mip !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL meip_set: got %h expected 00000800", mip);
    end
    csr_addr = 12'h344;
    #1;
    n_checks++;
    if (csr_rdata !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL mip_read: got %h expected 00000800", csr_rdata);
    end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    n_checks++;
    if (mip !== 32'h0) begin
      n_fail++;
      $display("FAIL meip_ack_clear: got %h expected 00000000", mip);
    end
    $display("intr edge -> mip set then acked, mip=%h", mip);
  endtask

  task automatic test_trap_mret();
    csr_addr  = 12'h300;
    csr_rw    = 1'b1;
    wsta      = 1'b1;
    csr_wdata = 32'h0000_0008;
    tick();
    clear_strobes();
    n_checks++;
    if (mstatus !== 32'h0000_1808 || csr_rdata !== 32'h0000_1808) begin
      n_fail++;
      $display("FAIL mstatus_write: got %h/%h expected 00001808", mstatus, csr_rdata);
    end
    exc = 1'b1; wsta = 1'b1; wcau = 1'b1; wepc = 1'b1;
    intr_ack = 1'b1; pc = 32'h0000_0040; cause_in = 32'h5;
    tick();
    clear_strobes();
    n_checks++;
    if (mstatus !== 32'h0000_1880) begin
      n_fail++;
      $display("FAIL trap_mstatus: got %h expected 00001880", mstatus);
    end
    n_checks++;
    if (mcause !== 32'h8000_000B) begin
      n_fail++;
      $display("FAIL trap_mcause_intr: got %h expected 8000000b", mcause);
    end
    n_checks++;
    if (mepc !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL trap_mepc: got %h expected 00000040", mepc);
    end
    $display("trap: mstatus=%h mcause=%h mepc=%h", mstatus, mcause, mepc);
    mret = 1'b1; wsta = 1'b1;
    tick();
    clear_strobes();
    n_checks++;
    if (mstatus !== 32'h0000_1888) begin
      n_fail++;
      $display("FAIL mret_mstatus: got %h expected 00001888", mstatus);
    end
    // Synchronous exception, with a competing mtvec write that must be blocked.
    exc = 1'b1; wsta = 1'b1; wcau = 1'b1; wepc = 1'b1;
    cause_in = 32'h2; pc = 32'h0000_0047;
    csr_rw = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0100;
    tick();
    clear_strobes();
    n_checks++;
    if (mstatus !== 32'h0000_1880 || mcause !== 32'h2 || mepc !== 32'h0000_0044) begin
      n_fail++;
      $display("FAIL trap2: got mstatus=%h mcause=%h mepc=%h expected 00001880 00000002 00000044", mstatus, mcause, mepc);
    end
    n_checks++;
    if (exc_base !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL exc_blocks_mtvec: got %h expected 00000008", exc_base);
    end
  endtask

  task automatic test_mie_write();
    csr_rw = 1'b1; csr_addr = 12'h304; csr_wdata = 32'hFFFF_FFFF; exc = 1'b1;
    tick();
    n_checks++;
    if (mie !== 32'h0) begin
      n_fail++;
      $display("FAIL mie_exc_block: got %h expected 00000000", mie);
    end
    exc = 1'b0;
    #1;
    n_checks++;
    if (csr_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mie_read_before_write: got %h expected 00000000", csr_rdata);
    end
    tick();
    clear_strobes();
    n_checks++;
    if (mie !== 32'h0000_0800 || csr_rdata !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL mie_write: got %h/%h expected 00000800", mie, csr_rdata);
    end
    $display("mie write: mie=%h", mie);
  endtask

  task automatic test_csr_misc();
    csr_rw = 1'b1; csr_addr = 12'h344; csr_wdata = 32'hFFFF_FFFF;
    tick();
    n_checks++;
    if (mip !== 32'h0) begin
      n_fail++;
      $display("FAIL mip_write_ignored: got %h expected 00000000", mip);
    end
    csr_addr = 12'h305; csr_wdata = 32'h0000_0123;
    tick();
    n_checks++;
    if (exc_base !== 32'h0000_0120 || csr_rdata !== 32'h0000_0120) begin
      n_fail++;
      $display("FAIL mtvec_write: got %h/%h expected 00000120", exc_base, csr_rdata);
    end
    clear_strobes();
    csr_addr = 12'h7C0;
    #1;
    n_checks++;
    if (csr_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got %h expected 00000000", csr_rdata);
    end
    csr_rw = 1'b1; wepc = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_1003;
    tick();
    clear_strobes();
    n_checks++;
    if (mepc !== 32'h0000_1000 || csr_rdata !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL mepc_write: got %h/%h expected 00001000", mepc, csr_rdata);
    end
    csr_rw = 1'b1; wcau = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h0000_0007;
    tick();
    clear_strobes();
    n_checks++;
    if (mcause !== 32'h7 || csr_rdata !== 32'h7) begin
      n_fail++;
      $display("FAIL mcause_write: got %h/%h expected 00000007", mcause, csr_rdata);
    end
    $display("csr misc: mtvec=%h mepc=%h mcause=%h", exc_base, mepc, mcause);
  endtask

  task automatic test_ack_collision();
    intr = 1'b0;
    repeat (3) tick();
    intr = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (mip !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL collision_first_set: got %h expected 00000800", mip);
    end
    intr = 1'b0;
    repeat (3) tick();
    intr = 1'b1;
    tick();
    tick();
    // The new edge is being detected this cycle; acknowledge the old one now.
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    n_checks++;
    if (mip !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL collision_set_wins: got %h expected 00000800", mip);
    end
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    n_checks++;
    if (mip !== 32'h0) begin
      n_fail++;
      $display("FAIL collision_ack_after: got %h expected 00000000", mip);
    end
    $display("ack collision: mip=%h", mip);
  endtask

  task automatic test_reset_midchain();
    intr = 1'b0;
    repeat (3) tick();
    intr = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (mstatus !== 32'h0 || mie !== 32'h0 || mepc !== 32'h0 || mcause !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_csrs: got mstatus=%h mie=%h mepc=%h mcause=%h expected all 0", mstatus, mie, mepc, mcause);
    end
    n_checks++;
    if (exc_base !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL async_reset_mtvec: got %h expected 00000008", exc_base);
    end
    intr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (mip !== 32'h0 || intr_synced !== 1'b0) begin
        n_fail++;
        $display("FAIL lost_edge_cycle%0d: got mip=%h synced=%b expected 0", i, mip, intr_synced);
      end
    end
    $display("reset mid-chain: mip=%h", mip);
  endtask

  task automatic test_reset_held_intr();
    intr  = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (intr_synced !== 1'b1 || mip !== 32'h0) begin
      n_fail++;
      $display("FAIL held_intr_cycle2: got synced=%b mip=%h expected 1 00000000", intr_synced, mip);
    end
    tick();
    n_checks++;
    if (mip !== 32'h0000_0800) begin
      n_fail++;
      $display("FAIL held_intr_cycle3: got %h expected 00000800", mip);
    end
    $display("intr held across reset: mip=%h", mip);
  endtask

  initial begin
    test_reset();
    test_intr_sync();
    test_trap_mret();
    test_mie_write();
    test_csr_misc();
    test_ack_collision();
    test_reset_midchain();
    test_reset_held_intr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_csr_intr.md
SC_CSR_INTR -- requirements
Module: sc_csr_intr

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0008: reset value of mtvec.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port intr  input  1  raw external interrupt line, asynchronous to clk.
REQ-005 SHALL have port intr_synced  output  1  intr after two-flop synchronizer.
REQ-006 SHALL have port intr_ack  input  1  interrupt taken this cycle, from control unit.
REQ-007 SHALL have ports exc, mret, wsta, wcau, wepc, csr_rw  input  1 each  control-unit trap/CSR strobes.
REQ-008 SHALL have port csr_addr  input  12  CSR address of current instruction.
REQ-009 SHALL have port csr_wdata  input  32  rs1 value for csrrw.
REQ-010 SHALL have port cause_in  input  32  synchronous exception cause from control unit.
REQ-011 SHALL have port pc  input  32  address of current instruction.
REQ-012 SHALL have ports mstatus, mie, mip, mepc, mcause  output  32 each  CSR contents.
REQ-013 SHALL have port exc_base  output  32  trap vector, {mtvec[31:2],2'b00}.
REQ-014 SHALL have port csr_rdata  output  32  combinational CSR read data.

Function
REQ-015 intr SHALL pass through two flops; intr_synced = second flop; latency 2 cycles.
REQ-016 Rising edge of intr_synced (third flop holds previous value) SHALL set mip[11] (MEIP) at the next clk edge.
REQ-017 mip[11] SHALL clear on a clk edge with intr_ack=1; if a new rising edge coincides with intr_ack, set wins and mip[11] stays 1.
REQ-018 All other mip bits SHALL read 0; csrrw to mip (0x344) SHALL be ignored.
REQ-019 mstatus SHALL implement only MIE[3], MPIE[7], MPP[12:11]; other bits read 0.
REQ-020 On wsta with exc=1: MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-021 On wsta with exc=0, mret=1: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-022 On wsta with exc=0, mret=0 (csrrw 0x300): implemented bits <= csr_wdata bits; MPP forced 2'b11.
REQ-023 On wcau with exc=1: mcause <= intr_ack ? 32'h8000_000B : cause_in; with exc=0: mcause <= csr_wdata.
REQ-024 On wepc with exc=1: mepc <= {pc[31:2],2'b00}; with exc=0: mepc <= {csr_wdata[31:2],2'b00}.
REQ-025 mie SHALL be written with csr_wdata when csr_rw=1, csr_addr=0x304, exc=0; only bit 11 implemented.
REQ-026 mtvec SHALL be written with {csr_wdata[31:2],2'b00} when csr_rw=1, csr_addr=0x305, exc=0.
REQ-027 exc SHALL block every csr_rw write in the same cycle (trap priority: exc > mret > csr_rw).
REQ-028 csr_rdata SHALL return mstatus/mie/mtvec/mepc/mcause/mip for 0x300/0x304/0x305/0x341/0x342/0x344; else 32'h0.
REQ-029 csr_rdata SHALL show pre-write values: read-before-write within a cycle.
REQ-030 All CSR outputs SHALL be registered; no combinational path from strobes to mstatus/mie/mip/mepc/mcause.

Reset
REQ-031 reset=1 SHALL immediately force sync flops, mip, mstatus, mie, mepc, mcause to 0 and mtvec to MTVEC_RESET.
REQ-032 An intr edge whose synchronizer chain is cleared by reset SHALL be lost; no MEIP after release without a new edge.
REQ-033 First edge-detect after reset release SHALL compare against 0, so intr held high across reset sets MEIP 3 cycles after release.

Structure
REQ-034 Package sc_csr_pkg SHALL hold CSR address constants, mstatus bit indices, MEIP index, interrupt cause 32'h8000_000B.
REQ-035 Synchronizer and edge detect SHALL be sub-module sc_intr_sync (clk, reset, intr -> intr_synced, intr_rise).
REQ-036 Block SHALL have no latches and a single always block per CSR.

Verification
REQ-037 Reset, then read all six addresses -> 0 except 0x305 = 32'h0000_0008.
REQ-038 intr 0->1 at cycle 0 -> intr_synced=1 at cycle 2, mip=32'h0000_0800 at cycle 3; intr_ack pulse -> mip=0 next cycle.
REQ-039 mstatus=32'h8, exc=1, wsta/wcau/wepc=1, intr_ack=1, pc=32'h0000_0040 -> mstatus=32'h1880, mcause=32'h8000_000B, mepc=32'h40.
REQ-040 Then mret=1, wsta=1 -> mstatus=32'h1888.
REQ-041 csr_rw=1, csr_addr=0x304, csr_wdata=32'hFFFF_FFFF, exc=1 -> mie unchanged 0; same with exc=0 -> mie=32'h800.
REQ-042 New intr edge arrives in intr_ack cycle -> mip[11] remains 1; assert reset mid-chain -> mip=0, no later MEIP.
